// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer and its PC register, memory, branch unit and consumer.
interface fetch_sequencer_if;
  logic [7:0]  pc_value;
  logic        pc_inc;
  logic        pc_load;
  logic [7:0]  pc_load_data;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        branch_valid;
  logic [7:0]  branch_target;
  logic        instr_valid;
  logic [15:0] instr_out;
  logic        instr_ready;
  logic        fetch_err;

  modport master (
    input  pc_value, mem_ack, mem_rdata, branch_valid, branch_target, instr_ready,
    output pc_inc, pc_load, pc_load_data, mem_req, mem_addr, instr_valid, instr_out, fetch_err
  );

  modport slave (
    output pc_value, mem_ack, mem_rdata, branch_valid, branch_target, instr_ready,
    input  pc_inc, pc_load, pc_load_data, mem_req, mem_addr, instr_valid, instr_out, fetch_err
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Two-byte instruction fetch sequencer: opcode then operand, with branch redirect and memory timeout.
module fetch_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic              clk,
  input logic              rst,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {F_OP, F_ARG, HOLD, ERR} state_t;

  localparam logic [7:0] TO = TIMEOUT[7:0];

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [15:0] instr_q, instr_nxt;
  logic        req, ack, inc, load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= F_OP;
      cnt     <= '0;
      instr_q <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      instr_q <= instr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    instr_nxt = instr_q;
    inc       = 1'b0;
    load      = 1'b0;
    req       = (state == F_OP) || (state == F_ARG);
    ack       = bus.mem_ack && req;

    // Branch outranks everything, including an ack or a consumer handshake in the same cycle.
    if (bus.branch_valid) begin
      load      = 1'b1;
      state_nxt = F_OP;
      instr_nxt = '0;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        F_OP, F_ARG: begin
          if (ack) begin
            inc     = 1'b1;
            cnt_nxt = '0;
            if (state == F_OP) begin
              instr_nxt[15:8] = bus.mem_rdata;
              state_nxt       = F_ARG;
            end else begin
              instr_nxt[7:0] = bus.mem_rdata;
              state_nxt      = HOLD;
            end
          end else if (cnt + 8'd1 == TO) begin
            state_nxt = ERR;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
        HOLD: begin
          if (bus.instr_ready) state_nxt = F_OP;
        end
        ERR: ;
        default: state_nxt = F_OP;
      endcase
    end
  end

  // Outputs are gated by rst so they read zero during the reset cycle itself.
  assign bus.mem_req      = ~rst & req;
  assign bus.mem_addr     = (~rst & req) ? bus.pc_value : '0;
  assign bus.pc_inc       = ~rst & inc;
  assign bus.pc_load      = ~rst & load;
  assign bus.pc_load_data = (~rst & load) ? bus.branch_target : '0;
  assign bus.instr_valid  = ~rst & (state == HOLD);
  assign bus.instr_out    = rst ? '0 : instr_q;
  assign bus.fetch_err    = ~rst & (state == ERR);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a PC register model, scripted memory acks and an instruction scoreboard.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic pc_wr;
  logic [7:0] pc_wr_data;
  logic [7:0] pc;

  int n_pass = 0;
  int n_total = 0;
  logic [15:0] exp_q[$];

  fetch_sequencer_if bus();

  fetch_sequencer #(.TIMEOUT(15)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  // PC register: increment wins over load; pc_wr lets the bench preset it.
  always @(posedge clk) begin
    if (pc_wr)                pc <= pc_wr_data;
    else if (bus.pc_inc)      pc <= pc + 8'd1;
    else if (bus.pc_load)     pc <= bus.pc_load_data;
  end
  assign bus.pc_value = pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard monitor: every accepted instruction must match the next expected one.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1 && bus.branch_valid === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_instr: got %0h expected none at %0t", bus.instr_out, $time);
      end else begin
        check("instr_out", {16'h0, bus.instr_out}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_byte(input int unsigned delay, input logic [7:0] addr, input logic [7:0] data);
    for (int unsigned i = 0; i < delay; i++) begin
      bus.mem_ack = 1'b0;
      #1;
      check("wait_mem_req", {31'h0, bus.mem_req}, 32'h1);
      check("wait_mem_addr", {24'h0, bus.mem_addr}, {24'h0, addr});
      check("wait_pc_inc", {31'h0, bus.pc_inc}, 32'h0);
      tick();
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = data;
    #1;
    check("ack_mem_addr", {24'h0, bus.mem_addr}, {24'h0, addr});
    check("ack_pc_inc", {31'h0, bus.pc_inc}, 32'h1);
    tick();
    bus.mem_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pc_wr = 1'b1;
    pc_wr_data = 8'h10;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    bus.branch_valid = 1'b0;
    bus.branch_target = '0;
    bus.instr_ready = 1'b0;
    tick();

    // Reset overrides branch, ack and ready
    bus.mem_ack = 1'b1;
    bus.branch_valid = 1'b1;
    bus.branch_target = 8'h55;
    bus.instr_ready = 1'b1;
    #1;
    check("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
    check("rst_mem_addr", {24'h0, bus.mem_addr}, 32'h0);
    check("rst_pc_inc", {31'h0, bus.pc_inc}, 32'h0);
    check("rst_pc_load", {31'h0, bus.pc_load}, 32'h0);
    check("rst_pc_load_data", {24'h0, bus.pc_load_data}, 32'h0);
    check("rst_instr_valid", {31'h0, bus.instr_valid}, 32'h0);
    check("rst_fetch_err", {31'h0, bus.fetch_err}, 32'h0);
    check("rst_instr_out", {16'h0, bus.instr_out}, 32'h0);
    tick();

    rst = 1'b0;
    pc_wr = 1'b0;
    bus.mem_ack = 1'b0;
    bus.branch_valid = 1'b0;
    bus.instr_ready = 1'b0;
    #1;
    check("post_rst_mem_req", {31'h0, bus.mem_req}, 32'h1);
    check("post_rst_mem_addr", {24'h0, bus.mem_addr}, 32'h10);

    // Basic fetch A5 3C from 0x10
    fetch_byte(0, 8'h10, 8'hA5);
    exp_q.push_back(16'hA53C);
    fetch_byte(0, 8'h11, 8'h3C);
    #1;
    check("hold_valid", {31'h0, bus.instr_valid}, 32'h1);
    check("hold_mem_req", {31'h0, bus.mem_req}, 32'h0);
    check("hold_pc", {24'h0, pc}, 32'h12);
    check("hold_instr", {16'h0, bus.instr_out}, 32'hA53C);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 8'hFF;
    #1;
    check("stray_ack_pc_inc", {31'h0, bus.pc_inc}, 32'h0);
    tick();
    bus.mem_ack = 1'b0;
    #1;
    check("hold2_valid", {31'h0, bus.instr_valid}, 32'h1);
    check("hold2_instr", {16'h0, bus.instr_out}, 32'hA53C);
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    #1;
    check("refetch_mem_req", {31'h0, bus.mem_req}, 32'h1);
    check("refetch_mem_addr", {24'h0, bus.mem_addr}, 32'h12);
    check("refetch_valid", {31'h0, bus.instr_valid}, 32'h0);

    // Slow memory: 4 wait cycles per byte
    fetch_byte(4, 8'h12, 8'h11);
    exp_q.push_back(16'h1122);
    fetch_byte(4, 8'h13, 8'h22);
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;

    // Branch collides with operand ack
    fetch_byte(0, 8'h14, 8'h77);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 8'h99;
    bus.branch_valid = 1'b1;
    bus.branch_target = 8'h80;
    #1;
    check("br_pc_load", {31'h0, bus.pc_load}, 32'h1);
    check("br_pc_load_data", {24'h0, bus.pc_load_data}, 32'h80);
    check("br_pc_inc", {31'h0, bus.pc_inc}, 32'h0);
    tick();
    bus.mem_ack = 1'b0;
    bus.branch_valid = 1'b0;
    #1;
    check("br_valid", {31'h0, bus.instr_valid}, 32'h0);
    check("br_mem_addr", {24'h0, bus.mem_addr}, 32'h80);
    check("br_instr_out", {16'h0, bus.instr_out}, 32'h0);

    // Timeout: 15 waiting cycles then ERR
    for (int unsigned i = 0; i < 15; i++) begin
      #1;
      check("to_err_low", {31'h0, bus.fetch_err}, 32'h0);
      check("to_mem_req", {31'h0, bus.mem_req}, 32'h1);
      tick();
    end
    #1;
    check("to_err_high", {31'h0, bus.fetch_err}, 32'h1);
    check("to_mem_req_low", {31'h0, bus.mem_req}, 32'h0);
    bus.mem_ack = 1'b1;
    #1;
    check("err_ack_pc_inc", {31'h0, bus.pc_inc}, 32'h0);
    tick();
    bus.mem_ack = 1'b0;
    #1;
    check("err_sticky", {31'h0, bus.fetch_err}, 32'h1);
    bus.branch_valid = 1'b1;
    bus.branch_target = 8'h00;
    #1;
    check("err_br_pc_load", {31'h0, bus.pc_load}, 32'h1);
    tick();
    bus.branch_valid = 1'b0;
    #1;
    check("err_clear", {31'h0, bus.fetch_err}, 32'h0);
    check("err_exit_mem_req", {31'h0, bus.mem_req}, 32'h1);
    check("err_exit_mem_addr", {24'h0, bus.mem_addr}, 32'h00);

    // Reset in F_ARG with opcode latched
    fetch_byte(0, 8'h00, 8'h5A);
    rst = 1'b1;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 8'h77;
    bus.branch_valid = 1'b1;
    bus.branch_target = 8'h33;
    bus.instr_ready = 1'b1;
    #1;
    check("midrst_mem_req", {31'h0, bus.mem_req}, 32'h0);
    check("midrst_pc_inc", {31'h0, bus.pc_inc}, 32'h0);
    check("midrst_pc_load", {31'h0, bus.pc_load}, 32'h0);
    check("midrst_instr_out", {16'h0, bus.instr_out}, 32'h0);
    tick();
    #1;
    check("midrst_pc", {24'h0, pc}, 32'h01);
    check("midrst_mem_req2", {31'h0, bus.mem_req}, 32'h0);
    rst = 1'b0;
    bus.mem_ack = 1'b0;
    bus.branch_valid = 1'b0;
    bus.instr_ready = 1'b0;
    #1;
    check("rel_mem_req", {31'h0, bus.mem_req}, 32'h1);
    check("rel_mem_addr", {24'h0, bus.mem_addr}, 32'h01);
    check("rel_instr_out", {16'h0, bus.instr_out}, 32'h0);
    exp_q.push_back(16'hC33C);
    fetch_byte(0, 8'h01, 8'hC3);
    fetch_byte(0, 8'h02, 8'h3C);
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;

    // PC wrap: opcode at FF, operand at 00
    pc_wr = 1'b1;
    pc_wr_data = 8'hFF;
    tick();
    pc_wr = 1'b0;
    fetch_byte(0, 8'hFF, 8'hE1);
    exp_q.push_back(16'hE10F);
    fetch_byte(0, 8'h00, 8'h0F);
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;

    // Branch together with consumer handshake discards the instruction
    fetch_byte(0, 8'h01, 8'h12);
    fetch_byte(0, 8'h02, 8'h34);
    #1;
    check("hb_valid", {31'h0, bus.instr_valid}, 32'h1);
    bus.instr_ready = 1'b1;
    bus.branch_valid = 1'b1;
    bus.branch_target = 8'h40;
    #1;
    check("hb_pc_load", {31'h0, bus.pc_load}, 32'h1);
    check("hb_pc_inc", {31'h0, bus.pc_inc}, 32'h0);
    tick();
    bus.instr_ready = 1'b0;
    bus.branch_valid = 1'b0;
    #1;
    check("hb_valid_after", {31'h0, bus.instr_valid}, 32'h0);
    check("hb_instr_out", {16'h0, bus.instr_out}, 32'h0);
    check("hb_mem_addr", {24'h0, bus.mem_addr}, 32'h40);

    tick();
    tick();
    check("scoreboard_empty", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
